// File: rtl/pb_select_ctrl.sv
// Pushbutton front end: synchronise, debounce, edge pulses, and momentary/toggle select.
// All outputs are registered; pulses and sel change on the same edge as pb_level.
module pb_select_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit PB_ACTIVE_LOW   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_raw,
   input  logic mode,
   output logic pb_level,
   output logic pb_press,
   output logic pb_release,
   output logic sel
);

   localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_pb_n;
   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             r_tog;
   logic             r_sel;

   logic [CNT_W-1:0] w_cnt_next;
   logic             w_level_next;
   logic             w_press_next;
   logic             w_release_next;
   logic             w_tog_next;
   logic             w_sel_next;

   assign w_pb_n = PB_ACTIVE_LOW ? ~pb_raw : pb_raw;

   // Any sample agreeing with the accepted level restarts the count, so glitches never accumulate.
   always_comb begin
      w_cnt_next   = r_cnt;
      w_level_next = r_level;
      if (r_s2 == r_level) begin
         w_cnt_next = '0;
      end else if (r_cnt == LP_TERM) begin
         w_level_next = r_s2;
         w_cnt_next   = '0;
      end else begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   assign w_press_next   = w_level_next & ~r_level;
   assign w_release_next = ~w_level_next & r_level;
   assign w_tog_next     = r_tog ^ w_press_next;
   assign w_sel_next     = mode ? w_tog_next : w_level_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_tog     <= 1'b0;
         r_sel     <= 1'b0;
      end else begin
         r_s1      <= w_pb_n;
         r_s2      <= r_s1;
         r_cnt     <= w_cnt_next;
         r_level   <= w_level_next;
         r_press   <= w_press_next;
         r_release <= w_release_next;
         r_tog     <= w_tog_next;
         r_sel     <= w_sel_next;
      end
   end

   assign pb_level   = r_level;
   assign pb_press   = r_press;
   assign pb_release = r_release;
   assign sel        = r_sel;

endmodule
